ps2_rx_decoder: RTL and testbench
=================================

Name: ps2_rx_decoder

Overview:
Parametrised PS/2 keyboard receiver that replaces the single-byte make/break latch used for paddle control. It adds clock deglitching, start, parity and stop checking, and an in-frame timeout with resync. It decodes the E0 (extended) and F0 (break) prefixes into one event per key action and keeps a held-state bit for a configurable set of tracked keys. It sits between the PS/2 pins and the game control logic.

Parameters:
FILTER_LEN, 4, number of consecutive identical synced samples of ps2k_clk required before the filtered clock changes level (1..15).
TIMEOUT_CYC, 100000, clk cycles allowed between filtered falling edges inside a frame before the frame is aborted (2 ms at 50 MHz).
NUM_TRACK, 4, number of tracked keys (1..8).
TRACK_CODES, {9'h172,9'h175,9'h01B,9'h01D}, packed 9-bit {ext,code} per slot; slot i is bits [9i+8:9i]. Defaults: slot0=W(1D), slot1=S(1B), slot2=Up(E0 75), slot3=Down(E0 72).

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  asynchronous active-low reset
ps2k_clk  input  1  raw PS/2 clock pin, asynchronous
ps2k_data  input  1  raw PS/2 data pin, asynchronous
ev_valid  output  1  one-cycle pulse: a key event is presented
ev_code  output  8  scan code of the event (prefixes stripped)
ev_ext  output  1  event was E0-prefixed
ev_break  output  1  event is a release (F0-prefixed)
key_held  output  NUM_TRACK  level: tracked key i is currently pressed
err_valid  output  1  one-cycle pulse: a frame was rejected
err_type  output  2  01 parity, 10 stop/framing, 11 timeout; valid with err_valid

Behaviour:
- Reset (asynchronous, rst_n=0): filtered clock=1, sync flops=1, FSM=IDLE, bit count=0, prefix flags=0, timeout counter=0. Outputs: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, key_held=0, err_valid=0, err_type=0. Reset mid-frame discards the partial frame; no event or error is produced.
- Input path: two-flop synchroniser on both pins. Filter counter: the filtered clock takes the new level only after FILTER_LEN consecutive synced samples differ from it. Shorter pulses are ignored. A falling edge of the filtered clock samples the synced data. Latency from raw edge to sample = 2+FILTER_LEN cycles.
- FSM states: IDLE, DATA, PARITY, STOP. Each transition happens on a filtered falling edge.
  - IDLE: data=0 → DATA with bit count 0. data=1 → stay in IDLE; no error is reported.
  - DATA: shift the data bit in LSB first. After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: always returns to IDLE. Checks are applied in priority order:
    - stop bit=0 → err 10;
    - else XOR(data byte, parity bit)≠1 (odd parity fails) → err 01;
    - else the byte is accepted.
- Timeout: the counter clears on every filtered falling edge and counts while the FSM is not in IDLE. When it reaches TIMEOUT_CYC: FSM→IDLE, bit count=0, err 11.
- Any error also clears both prefix flags.
- Error outputs: err_valid pulses 1 cycle, 1 cycle after the rejecting edge or the timeout. err_type holds its value until the next error.
- Accepted byte handling, applied 1 cycle after the stop edge:
  - E0: set ext flag; no event.
  - F0: set brk flag; no event.
  - E1: dropped; flags unchanged.
  - Any other byte: ev_valid=1 for 1 cycle with ev_code=byte, ev_ext=ext flag, ev_break=brk flag; then clear both flags. ev_code, ev_ext and ev_break hold their values until the next event.
- Tracked keys: on an event with {ev_ext,ev_code} equal to slot i, key_held[i] is set if the event is a make and cleared if it is a break. key_held updates in the same cycle as ev_valid. Typematic repeat makes leave the bit set. A break for a key that is not held has no effect.
- Simultaneous events: err_valid and ev_valid are never asserted together. One frame produces at most one of them.

Test Plan:
- Frames 1D (parity 1), then F0, 1D → ev 1D make, then ev 1D break. key_held[0] is 1 after the first frame and 0 after the third. No err_valid.
- Frames E0 75, then E0 F0 75 → ev_code=75 with ev_ext=1, ev_break=0, key_held[2]=1. Then ev_code=75 with ev_ext=1, ev_break=1, key_held[2]=0. No event is emitted for the prefix bytes.
- Frame 1D with parity bit=0 → err_valid with err_type=01. No ev_valid, key_held unchanged. The following good frame 1B sets key_held[1].
- Send start bit plus 4 data bits, then hold the clock high for >TIMEOUT_CYC → err_type=11 at exactly TIMEOUT_CYC cycles after the last edge. A subsequent full 1D frame decodes correctly.
- Inject 2-cycle low glitches on ps2k_clk in IDLE and mid-frame (FILTER_LEN=4) → FSM and bit count are unaffected; the frame still decodes to its correct value.
- Assert rst_n low after bit 3 of a frame, release it, then send 1D → no event or error from the aborted frame, all outputs at 0 during reset, and 1D decodes normally.

Source files
------------

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: deglitched clock, framed byte checks, in-frame timeout,
// E0/F0 prefix decoding into key events and held-state tracking for selected keys.
module ps2_rx_decoder #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned NUM_TRACK   = 4,
    parameter logic [9*NUM_TRACK-1:0] TRACK_CODES = {9'h172, 9'h175, 9'h01B, 9'h01D}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ps2k_clk,
    input  logic                 ps2k_data,
    output logic                 ev_valid,
    output logic [7:0]           ev_code,
    output logic                 ev_ext,
    output logic                 ev_break,
    output logic [NUM_TRACK-1:0] key_held,
    output logic                 err_valid,
    output logic [1:0]           err_type
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt;
    logic [3:0]      r_fcnt;
    logic [2:0]      r_bitcnt, w_bitcnt_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic            r_par, w_par_nx;
    logic [TO_W-1:0] r_tocnt;
    logic            r_ext, r_brk;
    logic            r_pv, w_pv;
    logic            r_pe, w_pe;
    logic [1:0]      r_petype, w_petype;
    logic [7:0]      r_pbyte;
    logic            w_differ, w_flip, w_fall;

    assign w_differ = (r_clk_s2 != r_filt);
    assign w_flip   = w_differ && (r_fcnt == 4'(FILTER_LEN - 1));
    assign w_fall   = w_flip && !r_clk_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2k_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2k_data;
            r_dat_s2 <= r_dat_s1;
            if (w_flip) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else if (w_differ) begin
                r_fcnt <= r_fcnt + 4'd1;
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // Frame FSM; the synced data bit is sampled in the cycle the filtered clock falls.
    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_pv        = 1'b0;
        w_pe        = 1'b0;
        w_petype    = 2'b00;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nx  = ST_DATA;
                        w_bitcnt_nx = '0;
                    end
                end
                ST_DATA: begin
                    w_shift_nx  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_nx = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nx = ST_PARITY;
                end
                ST_PARITY: begin
                    w_par_nx   = r_dat_s2;
                    w_state_nx = ST_STOP;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    if (!r_dat_s2) begin
                        w_pe     = 1'b1;
                        w_petype = 2'b10;
                    end else if (!(^{r_shift, r_par})) begin
                        w_pe     = 1'b1;
                        w_petype = 2'b01;
                    end else begin
                        w_pv = 1'b1;
                    end
                end
            endcase
        end else if (r_state != ST_IDLE && r_tocnt == TO_W'(TIMEOUT_CYC - 1)) begin
            w_state_nx  = ST_IDLE;
            w_bitcnt_nx = '0;
            w_pe        = 1'b1;
            w_petype    = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tocnt  <= '0;
            r_pv     <= 1'b0;
            r_pe     <= 1'b0;
            r_petype <= 2'b00;
            r_pbyte  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_shift  <= w_shift_nx;
            r_par    <= w_par_nx;
            r_tocnt  <= (w_fall || w_state_nx == ST_IDLE) ? '0 : r_tocnt + TO_W'(1);
            r_pv     <= w_pv;
            r_pe     <= w_pe;
            r_petype <= w_petype;
            r_pbyte  <= r_shift;
        end
    end

    // Byte/error stage: one cycle behind the stop edge (or timeout).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid  <= 1'b0;
            ev_code   <= '0;
            ev_ext    <= 1'b0;
            ev_break  <= 1'b0;
            key_held  <= '0;
            err_valid <= 1'b0;
            err_type  <= 2'b00;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            ev_valid  <= 1'b0;
            err_valid <= 1'b0;
            if (r_pe) begin
                err_valid <= 1'b1;
                err_type  <= r_petype;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
            end else if (r_pv) begin
                case (r_pbyte)
                    8'hE0: r_ext <= 1'b1;
                    8'hF0: r_brk <= 1'b1;
                    8'hE1: ;
                    default: begin
                        ev_valid <= 1'b1;
                        ev_code  <= r_pbyte;
                        ev_ext   <= r_ext;
                        ev_break <= r_brk;
                        r_ext    <= 1'b0;
                        r_brk    <= 1'b0;
                        for (int unsigned i = 0; i < NUM_TRACK; i++) begin
                            if ({r_ext, r_pbyte} == TRACK_CODES[9*i +: 9])
                                key_held[i] <= !r_brk;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_rx_decoder;

    localparam int unsigned FLT = 4;
    localparam int unsigned TO  = 200;
    localparam int unsigned H   = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2k_clk = 1'b1;
    logic       ps2k_data = 1'b1;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [3:0] key_held;
    logic       err_valid;
    logic [1:0] err_type;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int n_ev = 0;
    int n_err = 0;
    int err_cyc = 0;
    logic [7:0] l_code = '0;
    logic       l_ext = 1'b0;
    logic       l_brk = 1'b0;
    logic [1:0] l_etype = 2'b00;
    int both_hi = 0;
    bit glitch_en = 1'b0;

    ps2_rx_decoder #(
        .FILTER_LEN (FLT),
        .TIMEOUT_CYC(TO),
        .NUM_TRACK  (4),
        .TRACK_CODES({9'h172, 9'h175, 9'h01B, 9'h01D})
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2k_clk (ps2k_clk),
        .ps2k_data(ps2k_data),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_break (ev_break),
        .key_held (key_held),
        .err_valid(err_valid),
        .err_type (err_type)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (ev_valid && err_valid) both_hi++;
        if (ev_valid) begin
            n_ev++;
            l_code = ev_code;
            l_ext  = ev_ext;
            l_brk  = ev_break;
        end
        if (err_valid) begin
            n_err++;
            l_etype = err_type;
            err_cyc = cyc;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set up while clock high, then low and high phases of H cycles.
    task automatic ps2_bit(input logic b);
        ps2k_data = b;
        wait_cyc(H);
        ps2k_clk  = 1'b0;
        last_fall = cyc;
        wait_cyc(H);
        ps2k_clk = 1'b1;
        if (glitch_en) begin
            wait_cyc(7);
            ps2k_clk = 1'b0;
            wait_cyc(2);
            ps2k_clk = 1'b1;
            wait_cyc(3);
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2k_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, ~(^b), 1'b1);
    endtask

    task automatic check_ev(input string tag, input int cnt, input logic [7:0] code,
                            input logic ext, input logic brk, input logic [3:0] held);
        check({tag, "_count"}, n_ev, cnt);
        check({tag, "_code"}, l_code, code);
        check({tag, "_ext"}, l_ext, ext);
        check({tag, "_brk"}, l_brk, brk);
        check({tag, "_held"}, key_held, held);
    endtask

    initial begin
        int ev0, er0;
        wait_cyc(5);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_code", ev_code, 0);
        check("rst_ev_flags", {ev_ext, ev_break}, 0);
        check("rst_key_held", key_held, 0);
        check("rst_err", {err_valid, err_type}, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        // W make, W break
        send(8'h1D);
        check_ev("w_make", 1, 8'h1D, 0, 0, 4'b0001);
        send(8'hF0);
        check("f0_no_event", n_ev, 1);
        send(8'h1D);
        check_ev("w_break", 2, 8'h1D, 0, 1, 4'b0000);
        check("w_no_err", n_err, 0);

        // Up make, Up break
        send(8'hE0);
        check("e0_no_event", n_ev, 2);
        send(8'h75);
        check_ev("up_make", 3, 8'h75, 1, 0, 4'b0100);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_ev("up_break", 4, 8'h75, 1, 1, 4'b0000);

        // parity error, then S make
        send_raw(8'h1D, 1'b0, 1'b1);
        check("par_err_count", n_err, 1);
        check("par_err_type", l_etype, 2'b01);
        check("par_no_event", n_ev, 4);
        check("par_held", key_held, 4'b0000);
        send(8'h1B);
        check_ev("s_make", 5, 8'h1B, 0, 0, 4'b0010);

        // stop bit error
        send_raw(8'h1D, 1'b1, 1'b0);
        check("stop_err_count", n_err, 2);
        check("stop_err_type", l_etype, 2'b10);
        check("stop_no_event", n_ev, 5);

        // error clears pending E0 prefix
        send(8'hE0);
        send_raw(8'h1D, 1'b0, 1'b1);
        send(8'h75);
        check_ev("prefix_cleared", 6, 8'h75, 0, 0, 4'b0010);
        check("prefix_err_count", n_err, 3);

        // E1 dropped
        send(8'hE1);
        check("e1_no_event", n_ev, 6);
        check("e1_no_err", n_err, 3);

        // timeout after start + 4 data bits
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2k_data = 1'b1;
        er0 = n_err;
        for (int i = 0; i < int'(TO) + 100 && n_err == er0; i++) @(negedge clk);
        check("to_err_count", n_err, er0 + 1);
        check("to_err_type", l_etype, 2'b11);
        check("to_latency", err_cyc - last_fall, FLT + 3 + TO);
        wait_cyc(10);
        send(8'h1D);
        check_ev("to_recover", 7, 8'h1D, 0, 0, 4'b0011);

        // glitches in idle and mid-frame
        er0 = n_err;
        ps2k_clk = 1'b0;
        wait_cyc(2);
        ps2k_clk = 1'b1;
        wait_cyc(20);
        glitch_en = 1'b1;
        send(8'h1C);
        glitch_en = 1'b0;
        check_ev("glitch_frame", 8, 8'h1C, 0, 0, 4'b0011);
        check("glitch_no_err", n_err, er0);

        // reset mid-frame
        ev0 = n_ev;
        er0 = n_err;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_held", key_held, 0);
        check("midrst_ev", {ev_valid, ev_code, ev_ext, ev_break}, 0);
        check("midrst_err", {err_valid, err_type}, 0);
        ps2k_clk  = 1'b1;
        ps2k_data = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(TO + 20);
        check("midrst_no_event", n_ev, ev0);
        check("midrst_no_err", n_err, er0);
        send(8'h1D);
        check_ev("midrst_recover", ev0 + 1, 8'h1D, 0, 0, 4'b0001);

        check("never_ev_and_err", both_hi, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
